// File: rtl/mcpu_ram_responder.sv
// Single-port word RAM serving MCPU data accesses through a strobe/ready handshake
// with programmable wait states; idle cycles are spent on instruction fetches.
module mcpu_ram_responder #(
  parameter int WORD_SIZE   = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_SIZE-1:0]  datawr,
  output logic [WORD_SIZE-1:0]  datard,
  output logic                  ready,
  output logic                  err,
  input  logic [ADDR_WIDTH-1:0] instraddr,
  output logic [WORD_SIZE-1:0]  instrrd,
  output logic                  instr_valid
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

  state_t                  state;
  logic [WORD_SIZE-1:0]    mem [DEPTH];
  logic                    req;
  logic                    req_q;
  logic                    accept;
  logic [2:0]              wait_cnt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [WORD_SIZE-1:0]    wdata_q;
  logic                    wr_q;
  logic                    conflict_q;
  logic [ADDR_WIDTH-1:0]   fetch_tag;
  logic                    fetched;
  logic                    mem_we;

  assign req         = we | re;
  assign accept      = (state == IDLE) && req && !req_q;
  // A reset landing on the ACCESS edge must drop the pending write.
  assign mem_we      = !reset && (state == ACCESS) && wr_q && !conflict_q;
  assign instr_valid = fetched && (fetch_tag == instraddr);

  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= wdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      datard     <= '0;
      ready      <= 1'b0;
      err        <= 1'b0;
      instrrd    <= '0;
      fetched    <= 1'b0;
      fetch_tag  <= '0;
      wait_cnt   <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      req_q <= req;
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q     <= addr;
            wdata_q    <= datawr;
            wr_q       <= we;
            conflict_q <= we & re;
            if (we & re) err <= 1'b1;
            if (WAIT_STATES == 0) begin
              state <= ACCESS;
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end else begin
            instrrd   <= mem[instraddr];
            fetch_tag <= instraddr;
            fetched   <= 1'b1;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) state <= ACCESS;
          else                wait_cnt <= wait_cnt - 3'd1;
        end
        ACCESS: begin
          ready <= 1'b1;
          state <= IDLE;
          if (!conflict_q) begin
            if (wr_q) begin
              if (addr_q == fetch_tag) fetched <= 1'b0;
            end else begin
              datard <= mem[addr_q];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
